grf_sb: RTL and testbench

Parametrised general register file with a per-register pending-write scoreboard, for the pipelined MIPS core. It replaces the fixed 32x32, two-read-port register file in decode. It adds three things: a configurable number of read ports, issue and writeback tracking of outstanding writes, and a per-port ready flag that the hazard unit uses to stall decode. Writes come from the W stage; issues come from D when an instruction with a destination register leaves decode.

---
 rtl/grf_sb_if.sv | 37 +++
 rtl/grf_sb.sv | 113 +++++++++++
 tb/tb_grf_sb.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/grf_sb_if.sv
`default_nettype none
// ============================================================================
// Module      : grf_sb_if
// Description : Bus bundle for the scoreboarded general register file.
//               Carries the read ports, the writeback port, the issue port
//               and the scoreboard status outputs.
// Revision    : 1.0  initial release
// ============================================================================
interface grf_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
);
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_ready;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  iss_en;
  logic [ADDR_W-1:0]     iss_addr;
  logic                  iss_stall;
  logic                  pend_err;

  // Pipeline side: drives addresses, writebacks and issues.
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_ready, iss_stall, pend_err
  );

  // Register file side.
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_ready, iss_stall, pend_err
  );
endinterface
`default_nettype wire

// File: rtl/grf_sb.sv
`default_nettype none
// ============================================================================
// Module      : grf_sb
// Description : Parametrised general register file with NRD combinational
//               read ports and a per-register pending-write scoreboard.
//               Register 0 reads as zero and is never pending.
//               Optional macro GRF_BYPASS_EN: same-cycle forwarding of the
//               writeback data and ready status to matching read ports.
// Revision    : 1.0  initial release
// ============================================================================
module grf_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int PEND_W = 2
) (
  input  wire        clk,
  input  wire        rst,
  grf_sb_if.slave    bus
);

  localparam int          DEPTH   = 2**ADDR_W;
  localparam [PEND_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [PEND_W-1:0] cnt  [DEPTH];
  logic              pend_err_r;
  logic [DEPTH-1:0]  inc_vec;
  logic [DEPTH-1:0]  dec_vec;
  logic              wr_live;
  logic              iss_live;
  logic              stall;

  // A writeback or issue to register 0 is ignored entirely.
  assign wr_live  = bus.wr_en  && (bus.wr_addr  != '0);
  assign iss_live = bus.iss_en && (bus.iss_addr != '0);

  // Saturated counter: the issue is refused and the upstream retries.
  assign stall = iss_live && (cnt[bus.iss_addr] == CNT_MAX);

  assign bus.iss_stall = stall;
  assign bus.pend_err  = pend_err_r;

  // Decode per-register increment/decrement requests.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < DEPTH; r++) begin
      inc_vec[r] = iss_live && !stall && (bus.iss_addr == ADDR_W'(r));
      dec_vec[r] = wr_live && (bus.wr_addr == ADDR_W'(r));
    end
  end

  // Register storage, pending counters and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      pend_err_r <= 1'b0;
    end else begin
      if (wr_live) begin
        regs[bus.wr_addr] <= bus.wr_data;
        // Writeback with nothing outstanding is an unmatched write.
        if (cnt[bus.wr_addr] == '0) begin
          pend_err_r <= 1'b1;
        end
      end
      for (int r = 1; r < DEPTH; r++) begin
        case ({inc_vec[r], dec_vec[r]})
          2'b10: cnt[r] <= cnt[r] + PEND_W'(1);
          2'b01: begin
            if (cnt[r] != '0) begin
              cnt[r] <= cnt[r] - PEND_W'(1);
            end
          end
          2'b11: begin
            // Net zero change, except an empty counter picks up the issue.
            if (cnt[r] == '0) begin
              cnt[r] <= PEND_W'(1);
            end
          end
          default: cnt[r] <= cnt[r];
        endcase
      end
    end
  end

  generate
    for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] stored;
      logic              idle;

      assign addr   = bus.rd_addr[i*ADDR_W +: ADDR_W];
      assign stored = (addr == '0) ? '0 : regs[addr];
      assign idle   = (cnt[addr] == '0);

`ifdef GRF_BYPASS_EN
      logic hit;
      assign hit = wr_live && (addr == bus.wr_addr);
      assign bus.rd_data[i*DATA_W +: DATA_W] = hit ? bus.wr_data : stored;
      assign bus.rd_ready[i] = idle || (hit && (cnt[addr] == PEND_W'(1)));
`else
      assign bus.rd_data[i*DATA_W +: DATA_W] = stored;
      assign bus.rd_ready[i] = idle;
`endif
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_grf_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_grf_sb
// Description : Directed self-checking bench for grf_sb (DATA_W=32,
//               ADDR_W=5, NRD=2, PEND_W=2). Expectations follow the
//               GRF_BYPASS_EN setting of the build.
// Revision    : 1.0  initial release
// ============================================================================
module tb_grf_sb;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  grf_sb_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) bus ();

  grf_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .PEND_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr = {a1, a0};
  endtask

  task automatic idle_in();
    bus.wr_en  = 1'b0;
    bus.iss_en = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.rd_addr  = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
    tick();
    rst = 1'b0;

    // Reset state
    set_rd(5'd5, 5'd31);
    #1;
    check("rst_data0", bus.rd_data[31:0], 32'h0);
    check("rst_data1", bus.rd_data[63:32], 32'h0);
    check("rst_ready", {30'd0, bus.rd_ready}, 32'h3);
    check("rst_perr", {31'd0, bus.pend_err}, 32'h0);
    check("rst_stall", {31'd0, bus.iss_stall}, 32'h0);

    // Register 0 ignores issue and writeback
    bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
    #1;
    check("r0_stall", {31'd0, bus.iss_stall}, 32'h0);
    tick();
    idle_in();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hDEADBEEF;
    tick();
    idle_in();
    set_rd(5'd0, 5'd0);
    #1;
    check("r0_data", bus.rd_data[31:0], 32'h0);
    check("r0_ready", {31'd0, bus.rd_ready[0]}, 32'h1);
    check("r0_perr", {31'd0, bus.pend_err}, 32'h0);

    // Scoreboard saturation on $8
    set_rd(5'd8, 5'd5);
    bus.iss_en = 1'b1; bus.iss_addr = 5'd8;
    #1;
    check("sb_nostall", {31'd0, bus.iss_stall}, 32'h0);
    tick(); tick(); tick();
    check("sb_stall", {31'd0, bus.iss_stall}, 32'h1);
    check("sb_ready", {30'd0, bus.rd_ready}, 32'h2);
    tick();  // stalled issue, must not change the count
    idle_in();
    for (int k = 1; k <= 3; k++) begin
      bus.wr_en = 1'b1; bus.wr_addr = 5'd8; bus.wr_data = 32'h100 + k;
      tick();
      idle_in();
      #1;
      if (k < 3) check("sb_busy", {31'd0, bus.rd_ready[0]}, 32'h0);
    end
    check("sb_done_ready", {31'd0, bus.rd_ready[0]}, 32'h1);
    check("sb_done_data", bus.rd_data[31:0], 32'h103);
    check("sb_perr", {31'd0, bus.pend_err}, 32'h0);

    // Write-to-read on $9 with one outstanding issue, both ports
    bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
    tick();
    idle_in();
    set_rd(5'd9, 5'd9);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h12345678;
    #1;
`ifdef GRF_BYPASS_EN
    check("byp_data0", bus.rd_data[31:0], 32'h12345678);
    check("byp_data1", bus.rd_data[63:32], 32'h12345678);
    check("byp_ready", {30'd0, bus.rd_ready}, 32'h3);
`else
    check("nobyp_data0", bus.rd_data[31:0], 32'h0);
    check("nobyp_data1", bus.rd_data[63:32], 32'h0);
    check("nobyp_ready", {30'd0, bus.rd_ready}, 32'h0);
`endif
    tick();
    idle_in();
    #1;
    check("wb_data0", bus.rd_data[31:0], 32'h12345678);
    check("wb_data1", bus.rd_data[63:32], 32'h12345678);
    check("wb_ready", {30'd0, bus.rd_ready}, 32'h3);

    // Unmatched writeback on $10
    bus.wr_en = 1'b1; bus.wr_addr = 5'd10; bus.wr_data = 32'hA5A5A5A5;
    #1;
    check("err_pre", {31'd0, bus.pend_err}, 32'h0);
    tick();
    idle_in();
    set_rd(5'd10, 5'd10);
    #1;
    check("err_flag", {31'd0, bus.pend_err}, 32'h1);
    check("err_data", bus.rd_data[31:0], 32'hA5A5A5A5);
    check("err_ready", {31'd0, bus.rd_ready[0]}, 32'h1);

    // Fresh reset, then simultaneous issue and writeback on $11 at count 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst2_perr", {31'd0, bus.pend_err}, 32'h0);
    check("rst2_data10", bus.rd_data[31:0], 32'h0);
    bus.iss_en = 1'b1; bus.iss_addr = 5'd11;
    bus.wr_en  = 1'b1; bus.wr_addr  = 5'd11; bus.wr_data = 32'h0BADF00D;
    tick();
    idle_in();
    set_rd(5'd11, 5'd10);
    #1;
    check("both_ready", {31'd0, bus.rd_ready[0]}, 32'h0);
    check("both_perr", {31'd0, bus.pend_err}, 32'h1);
    check("both_data", bus.rd_data[31:0], 32'h0BADF00D);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd11; bus.wr_data = 32'h11;
    tick();
    idle_in();
    #1;
    check("both_drain", {31'd0, bus.rd_ready[0]}, 32'h1);
    check("both_sticky", {31'd0, bus.pend_err}, 32'h1);

    // Reset mid-operation: $12 at count 2, reset wins over writeback
    bus.iss_en = 1'b1; bus.iss_addr = 5'd12;
    tick(); tick();
    idle_in();
    set_rd(5'd12, 5'd11);
    #1;
    check("mid_busy", {31'd0, bus.rd_ready[0]}, 32'h0);
    rst = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd12; bus.wr_data = 32'hFFFFFFFF;
    tick();
    rst = 1'b0;
    idle_in();
    #1;
    check("mid_ready", {30'd0, bus.rd_ready}, 32'h3);
    check("mid_data12", bus.rd_data[31:0], 32'h0);
    check("mid_data11", bus.rd_data[63:32], 32'h0);
    check("mid_perr", {31'd0, bus.pend_err}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
